// File: rtl/gray_position_ctrl_pkg.sv
// Shared types and helpers for the Gray-code position controller.
// Holds the FSM state enum, Gray/binary conversions and the half-range helper.
package gray_position_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers size-cast the 32-bit results down to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR over the Gray word recovers the binary value.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Half of the modular position space, 2^(w-1).
  function automatic int half_range(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/gray_position_ctrl_if.sv
// Command handshake and position output bundle for gray_position_ctrl.
// master: command source; slave: controller. abort exists only with
// GRAY_POSITION_CTRL_ABORT_EN defined.
interface gray_position_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic [WIDTH-1:0] gray_out;
  logic             dir;
  logic             step;
  logic             busy;
  logic             done;
`ifdef GRAY_POSITION_CTRL_ABORT_EN
  logic             abort;

  modport master (
    output cmd_valid,
    output cmd_target,
    output abort,
    input  cmd_ready,
    input  gray_out,
    input  dir,
    input  step,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  abort,
    output cmd_ready,
    output gray_out,
    output dir,
    output step,
    output busy,
    output done
  );
`else
  modport master (
    output cmd_valid,
    output cmd_target,
    input  cmd_ready,
    input  gray_out,
    input  dir,
    input  step,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    output cmd_ready,
    output gray_out,
    output dir,
    output step,
    output busy,
    output done
  );
`endif

endinterface

// File: rtl/gray_position_ctrl_step_counter.sv
// Up/down Gray counter with a binary shadow register, modulo 2^WIDTH.
// Ports: clk, rst (sync, active-high), en, dir (1=up), gray_out (registered).
module gray_step_counter
  import gray_position_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  always_comb begin
    pos_d = pos_q;
    if (en) begin
      pos_d = dir ? pos_q + 1'b1 : pos_q - 1'b1;
    end
    gray_d = WIDTH'(bin2gray(32'(pos_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      gray_q <= '0;
    end else begin
      pos_q  <= pos_d;
      gray_q <= gray_d;
    end
  end

  assign gray_out = gray_q;

endmodule

// File: rtl/gray_position_ctrl.sv
// Sequences a Gray counter to a commanded position along the shorter path.
// Ports: clk, rst (sync, active-high), bus (slave: cmd handshake, gray_out,
// dir, step, busy, done). Macro GRAY_POSITION_CTRL_ABORT_EN adds bus.abort.
module gray_position_ctrl
  import gray_position_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_position_ctrl_if.slave  bus
);

  localparam int HALF_RANGE = half_range(WIDTH);
  localparam int DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] pos;
  logic [WIDTH-1:0] next_pos;
  logic [WIDTH-1:0] up_dist;
  logic             fire;
  logic             abort_in;

`ifdef GRAY_POSITION_CTRL_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // Position is recovered from the counter's registered Gray output so
  // there is a single source of truth for where the shaft is.
  assign pos = WIDTH'(gray2bin(32'(gray)));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    div_d    = div_q;

    up_dist  = bus.cmd_target - pos;
    next_pos = dir_q ? pos + 1'b1 : pos - 1'b1;
    fire     = (state_q == MOVE) &&
               (div_q == DIV_W'(STEP_DIV - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          target_d = bus.cmd_target;
          if (up_dist == '0) begin
            state_d = DONE;
          end else begin
            // Exact half-range tie resolves upward.
            dir_d   = ({1'b0, up_dist} <=
                       (WIDTH+1)'(HALF_RANGE));
            div_d   = '0;
            state_d = MOVE;
          end
        end
      end
      MOVE: begin
        div_d = div_q + 1'b1;
        if (fire) begin
          div_d  = '0;
          step_d = 1'b1;
          if (next_pos == target_q) begin
            state_d = DONE;
          end
        end
        // A coincident step still lands; abort only ends the move.
        if (abort_in) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      div_q    <= div_d;
    end
  end

  gray_step_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (fire),
    .dir      (dir_q),
    .gray_out (gray)
  );

  assign bus.gray_out  = gray;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_gray_position_ctrl.sv
// Scoreboard bench for gray_position_ctrl (WIDTH=4, STEP_DIV=2).
// Expected steps are queued at command issue and popped on each step pulse.
module tb_gray_position_ctrl;

  localparam int W  = 4;
  localparam int SD = 2;
  localparam int N  = 1 << W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gray_position_ctrl_if #(.WIDTH(W)) bus ();

  gray_position_ctrl #(
    .WIDTH    (W),
    .STEP_DIV (SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] gray;
    logic         dir;
  } step_t;

  step_t exp_q[$];

  int n_chk    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int step_cnt = 0;
  int mpos     = 0;
  logic mdir   = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int g(input int p);
    logic [W-1:0] b;
    b = W'(p);
    return int'(b ^ (b >> 1));
  endfunction

  always @(negedge clk) begin : mon
    step_t e;
    if (bus.done) done_cnt++;
    if (bus.step) begin
      step_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexp_step", int'(bus.step), 0);
      end else begin
        e = exp_q.pop_front();
        chk("step_gray", int'(bus.gray_out), int'(e.gray));
        chk("step_dir", int'(bus.dir), int'(e.dir));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Model the direction choice, queue expected steps, present the command.
  task automatic issue(input int tgt, input bit hold, output int n);
    int up;
    int p;
    step_t e;
    chk("ready_before_cmd", int'(bus.cmd_ready), 1);
    up = (tgt - mpos + N) % N;
    if (up == 0) begin
      n = 0;
    end else if (up <= N / 2) begin
      mdir = 1'b1;
      n = up;
    end else begin
      mdir = 1'b0;
      n = N - up;
    end
    p = mpos;
    for (int k = 0; k < n; k++) begin
      p = mdir ? (p + 1) % N : (p + N - 1) % N;
      e.gray = W'(g(p));
      e.dir  = mdir;
      exp_q.push_back(e);
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = W'(tgt);
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic move(input int tgt, input string tag);
    int n;
    int cyc;
    int s0;
    int d0;
    s0 = step_cnt;
    d0 = done_cnt;
    issue(tgt, 1'b0, n);
    cyc = 0;
    tick();
    while (!bus.done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_done_seen"}, int'(bus.done), 1);
    chk({tag, "_latency"}, cyc + 1, n * SD + 1);
    chk({tag, "_busy"}, int'(bus.busy), 1);
    chk({tag, "_ready_in_done"}, int'(bus.cmd_ready), 0);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_final_gray"}, int'(bus.gray_out), g(tgt));
    chk({tag, "_steps"}, step_cnt - s0, n);
    mpos = tgt;
    exp_q.delete();
    tick();
    chk({tag, "_ready_after"}, int'(bus.cmd_ready), 1);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int s0;
    int d0;
    int cyc;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
`ifdef GRAY_POSITION_CTRL_ABORT_EN
    bus.abort      = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_gray", int'(bus.gray_out), 0);
    chk("rst_dir", int'(bus.dir), 0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ready", int'(bus.cmd_ready), 1);

    move(3, "t1_up3");
    chk("t1_dir", int'(bus.dir), 1);
    move(14, "t2_wrap_down");
    chk("t2_dir", int'(bus.dir), 0);
    move(0, "back_to_0");
    move(8, "t3_tie");
    chk("t3_dir", int'(bus.dir), 1);
    chk("t3_gray", int'(bus.gray_out), 12);

    // Same-position command with cmd_valid held through DONE.
    s0 = step_cnt;
    d0 = done_cnt;
    issue(8, 1'b1, n);
    tick();
    chk("t4_done", int'(bus.done), 1);
    chk("t4_ready_low", int'(bus.cmd_ready), 0);
    tick();
    chk("t4_held_ignored", int'(bus.done), 0);
    chk("t4_ready_back", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b0;
    tick();
    chk("t4_gray", int'(bus.gray_out), g(8));
    chk("t4_dir", int'(bus.dir), 1);
    chk("t4_steps", step_cnt - s0, 0);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // Reset in the middle of a 6-step move.
    s0 = step_cnt;
    d0 = done_cnt;
    issue(14, 1'b0, n);
    cyc = 0;
    while (step_cnt < s0 + 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t5_two_steps", step_cnt - s0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mpos = 0;
    mdir = 1'b0;
    chk("t5_gray", int'(bus.gray_out), 0);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_ready", int'(bus.cmd_ready), 1);
    chk("t5_dir", int'(bus.dir), 0);
    repeat (8) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_more_steps", step_cnt - s0, 2);

`ifdef GRAY_POSITION_CTRL_ABORT_EN
    s0 = step_cnt;
    d0 = done_cnt;
    issue(6, 1'b0, n);
    cyc = 0;
    while (step_cnt < s0 + 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    exp_q.delete();
    mpos = 2;
    chk("t6_done", int'(bus.done), 1);
    chk("t6_gray", int'(bus.gray_out), g(2));
    repeat (6) tick();
    chk("t6_ready", int'(bus.cmd_ready), 1);
    chk("t6_steps", step_cnt - s0, 2);
    chk("t6_done_cnt", done_cnt - d0, 1);
`endif

    for (int i = 0; i < 4; i++) begin
      move(int'($urandom_range(0, N - 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
